dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipelined core's M-stage port (CPU) and a debug/loader port (DBG) used to preload or inspect data memory while the core runs.
- Sits between the core/debug logic and the data memory instance, on the same slow core clock.
- CPU has fixed priority.
- A starvation counter guarantees DBG progress.
- A lock mode gives DBG exclusive multi-cycle ownership for bursts.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 8, cycles DBG may be denied before it is force-granted one slot. Legal range is 1..255.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write enable (1 = write).
- cpu_addr  in  AW  CPU byte address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU granted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid (registered).
- cpu_rdata  out  DW  CPU read data (registered).
- dbg_req  in  1  DBG access request.
- dbg_we  in  1  DBG write enable.
- dbg_addr  in  AW  DBG address.
- dbg_wdata  in  DW  DBG write data.
- dbg_lock  in  1  DBG requests exclusive ownership.
- dbg_gnt  out  1  DBG granted this cycle (combinational).
- dbg_rvalid  out  1  DBG read data valid (registered).
- dbg_rdata  out  DW  DBG read data (registered).
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory combinational read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to ARB and wait_cnt to 0.
  - cpu_rvalid, dbg_rvalid, cpu_rdata and dbg_rdata go to 0.
  - cpu_gnt, dbg_gnt and mem_we are forced to 0 while reset is low.
- States: ARB and DBG_LOCK.
- ARB grant rules (combinational, exactly one or zero grants per cycle):
  - dbg_gnt = dbg_req & (~cpu_req | wait_cnt==MAX_WAIT).
  - cpu_gnt = cpu_req & ~dbg_gnt.
- DBG_LOCK grant rules:
  - dbg_gnt = dbg_req.
  - cpu_gnt = 0, even when cpu_req=1.
- State transitions:
  - ARB -> DBG_LOCK when dbg_gnt & dbg_lock.
  - DBG_LOCK -> ARB when ~dbg_req | ~dbg_lock.
  - The cycle with dbg_lock=0 is still arbitrated as DBG_LOCK.
- wait_cnt:
  - In ARB: increments, saturating at MAX_WAIT, each cycle dbg_req & ~dbg_gnt.
  - Clears on dbg_gnt or ~dbg_req.
  - Held at 0 in DBG_LOCK.
- Memory mux:
  - mem_addr and mem_wdata come from the granted port.
  - When nothing is granted they come from the CPU.
  - mem_we = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we).
  - mem_we is never 1 without a grant.
- Read response, 1-cycle latency:
  - On a clock edge with a granted read (we=0), mem_rdata is captured into that port's rdata.
  - That port's rvalid is 1 in the following cycle.
  - rvalid is a single-cycle pulse per granted read and deasserts otherwise.
  - Writes produce no rvalid.
  - The non-granted port's rdata holds its last value.
- Back-to-back grants to the same or alternating ports are legal every cycle; throughput is one access per cycle.
- Reset asserted mid-lock or mid-read: the lock is dropped, the pending rvalid is lost, and no memory write occurs while reset is low.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, the block adds these output ports:
  - cpu_grant_cnt[15:0]
  - dbg_grant_cnt[15:0]
  - cpu_stall_cnt[15:0], counting cycles with cpu_req & ~cpu_gnt.
  - All three are saturating at 16'hFFFF and cleared by reset.
- When undefined, these ports and counters do not exist and the arbitration behaviour is identical.

Decomposition:
- Shared package:
  - State encoding (ARB=1'b0, DBG_LOCK=1'b1).
  - Port index constants PORT_CPU=0, PORT_DBG=1.
  - A default MAX_WAIT constant.
- One natural sub-module, dmem_arb_rsp: the per-port registered read-response stage, instantiated twice.
  - Inputs: granted, we, mem_rdata.
  - Outputs: rvalid, rdata.

Test Plan:
- Reset mid-lock:
  - Stimulus: enter DBG_LOCK, then pull reset=0 asynchronously between clock edges.
  - Required response: gnts, mem_we and rvalids drop to 0 immediately; after release the state is ARB and cpu_req=1 is granted on the first cycle.
- CPU-only traffic:
  - Stimulus: write 0xDEADBEEF to addr 0x40, then read 0x40.
  - Required response: cpu_gnt=1 both cycles and mem_we=1 only in the first; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF one cycle after the read.
- Contention with starvation:
  - Stimulus: cpu_req and dbg_req held high continuously, MAX_WAIT=8.
  - Required response: DBG is granted on the 9th cycle and every 9th cycle thereafter; the CPU gets the other 8 of every 9 cycles.
- Idle CPU:
  - Stimulus: dbg_req=1 with cpu_req=0.
  - Required response: dbg_gnt=1 immediately and wait_cnt stays 0.
- Lock burst:
  - Stimulus: DBG writes 4 words (addr 0x00..0x0C) with dbg_lock=1 while cpu_req=1.
  - Required response: cpu_gnt=0 for all 4 cycles; CPU granted the cycle after dbg_lock drops.
- Mixed reads:
  - Stimulus: DBG read of 0x10 in cycle N, CPU read of 0x20 in cycle N+1.
  - Required response: dbg_rvalid=1 only in N+1 and cpu_rvalid=1 only in N+2, each with the correct data.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e  : arbiter FSM state (ARB = normal arbitration, DBG_LOCK = debug owns memory)
//   PORT_CPU/DBG : index of each requester in the per-port vectors
//   DEF_MAX_WAIT : default starvation limit for the debug port
package dmem_arbiter_pkg;
  typedef enum logic {ARB = 1'b0, DBG_LOCK = 1'b1} arb_state_e;
  localparam int PORT_CPU     = 0;
  localparam int PORT_DBG     = 1;
  localparam int NUM_PORTS    = 2;
  localparam int DEF_MAX_WAIT = 8;
endpackage

// File: rtl/dmem_arbiter_rsp.sv
// Per-port registered read-response stage.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_granted      : this port owns the memory this cycle
//   i_we           : this port's access is a write
//   i_mem_rdata    : combinational memory read data
//   o_rvalid       : one-cycle pulse the cycle after a granted read
//   o_rdata        : captured read data, held until the next granted read
module dmem_arb_rsp
  import dmem_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_granted,
  input  logic          i_we,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata
);
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          w_rd;

  assign w_rd = i_granted & ~i_we;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= i_mem_rdata;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU (M-stage) vs DBG (debug/loader).
// CPU has fixed priority; DBG is force-granted after MAX_WAIT denied cycles; DBG may
// lock the memory for bursts. Reads return one cycle after the grant.
//   i_clk, i_reset (async, active low)
//   i_cpu_* / o_cpu_* : CPU request, grant and read response
//   i_dbg_* / o_dbg_* : DBG request (with lock), grant and read response
//   o_mem_* / i_mem_rdata : memory side (combinational read data)
// Optional: define DMEM_ARB_STATS_EN to add saturating 16-bit grant/stall counters
// (o_cpu_grant_cnt, o_dbg_grant_cnt, o_cpu_stall_cnt).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT  // 1..255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_gnt,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  input  logic          i_dbg_lock,
  output logic          o_dbg_gnt,
  output logic          o_dbg_rvalid,
  output logic [DW-1:0] o_dbg_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]   o_cpu_grant_cnt,
  output logic [15:0]   o_dbg_grant_cnt,
  output logic [15:0]   o_cpu_stall_cnt,
`endif
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);
  localparam logic [7:0] LP_MAX_WAIT = MAX_WAIT[7:0];

  arb_state_e r_state, w_state_nxt;
  logic [7:0] r_wait_cnt, w_wait_nxt;
  logic       w_cpu_gnt, w_dbg_gnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ARB;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = '0;
    w_dbg_gnt   = 1'b0;
    w_cpu_gnt   = 1'b0;
    case (r_state)
      ARB: begin
        w_dbg_gnt = i_dbg_req & (~i_cpu_req | (r_wait_cnt == LP_MAX_WAIT));
        w_cpu_gnt = i_cpu_req & ~w_dbg_gnt;
        if (w_dbg_gnt & i_dbg_lock) w_state_nxt = DBG_LOCK;
        // Count consecutive denied DBG cycles; any grant or idle cycle restarts it.
        if (i_dbg_req & ~w_dbg_gnt)
          w_wait_nxt = (r_wait_cnt == LP_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 8'd1;
      end
      DBG_LOCK: begin
        // The cycle in which lock drops is still served as a locked cycle.
        w_dbg_gnt = i_dbg_req;
        if (~i_dbg_req | ~i_dbg_lock) w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // Grants and write enable are combinational; mask them while reset is held so
  // nothing reaches the memory before the registers are released.
  assign o_cpu_gnt   = w_cpu_gnt & i_reset;
  assign o_dbg_gnt   = w_dbg_gnt & i_reset;
  assign o_mem_addr  = w_dbg_gnt ? i_dbg_addr  : i_cpu_addr;
  assign o_mem_wdata = w_dbg_gnt ? i_dbg_wdata : i_cpu_wdata;
  assign o_mem_we    = (o_cpu_gnt & i_cpu_we) | (o_dbg_gnt & i_dbg_we);

  logic [NUM_PORTS-1:0]         w_gnt, w_we, w_rvalid;
  logic [NUM_PORTS-1:0][DW-1:0] w_rdata;

  assign w_gnt[PORT_CPU] = o_cpu_gnt;
  assign w_gnt[PORT_DBG] = o_dbg_gnt;
  assign w_we[PORT_CPU]  = i_cpu_we;
  assign w_we[PORT_DBG]  = i_dbg_we;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    dmem_arb_rsp #(.DW(DW)) u_rsp (
      .i_clk       (i_clk),
      .i_rst_n     (i_reset),
      .i_granted   (w_gnt[p]),
      .i_we        (w_we[p]),
      .i_mem_rdata (i_mem_rdata),
      .o_rvalid    (w_rvalid[p]),
      .o_rdata     (w_rdata[p])
    );
  end

  assign o_cpu_rvalid = w_rvalid[PORT_CPU];
  assign o_cpu_rdata  = w_rdata[PORT_CPU];
  assign o_dbg_rvalid = w_rvalid[PORT_DBG];
  assign o_dbg_rdata  = w_rdata[PORT_DBG];

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_cpu_grant_cnt, r_dbg_grant_cnt, r_cpu_stall_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cpu_grant_cnt <= '0;
      r_dbg_grant_cnt <= '0;
      r_cpu_stall_cnt <= '0;
    end else begin
      if (o_cpu_gnt && r_cpu_grant_cnt != 16'hFFFF) r_cpu_grant_cnt <= r_cpu_grant_cnt + 16'd1;
      if (o_dbg_gnt && r_dbg_grant_cnt != 16'hFFFF) r_dbg_grant_cnt <= r_dbg_grant_cnt + 16'd1;
      if (i_cpu_req && !o_cpu_gnt && r_cpu_stall_cnt != 16'hFFFF)
        r_cpu_stall_cnt <= r_cpu_stall_cnt + 16'd1;
    end
  end

  assign o_cpu_grant_cnt = r_cpu_grant_cnt;
  assign o_dbg_grant_cnt = r_dbg_grant_cnt;
  assign o_cpu_stall_cnt = r_cpu_stall_cnt;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MW = 8;
  localparam logic H = 1'b1, L = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   cpu_grant_cnt, dbg_grant_cnt, cpu_stall_cnt;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .i_dbg_lock(dbg_lock), .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
`ifdef DMEM_ARB_STATS_EN
    .o_cpu_grant_cnt(cpu_grant_cnt), .o_dbg_grant_cnt(dbg_grant_cnt), .o_cpu_stall_cnt(cpu_stall_cnt),
`endif
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Memory instance: 64 words, combinational read, write on clock edge.
  logic [DW-1:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd; logic dl;
    logic e_cg, e_dg, e_we, e_crv; logic [31:0] e_crd; logic e_drv; logic [31:0] e_drd;
  } vec_t;
  vec_t vt [0:10];

  // Reference model state (behavioural: grant rules + starvation streak + shadow memory)
  bit            m_locked;
  int            m_starve;
  logic          m_pend_c, m_pend_d;
  logic [31:0]   m_rd_c, m_rd_d;
  logic [31:0]   ref_mem [0:63];

  initial begin
    int n, dg_cnt, cg_cnt;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // ---------------- reset state ----------------
    rst_n = 0;
    idle();
    cpu_req = 1; cpu_we = 1; dbg_req = 1; dbg_we = 1;
    #12;
    chk("rst_cpu_gnt", {31'b0, cpu_gnt}, 0);
    chk("rst_dbg_gnt", {31'b0, dbg_gnt}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_rvalids", {30'b0, cpu_rvalid, dbg_rvalid}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    idle();
    rst_n = 1;
    next_cyc();

    // ---------------- table-driven directed vectors ----------------
    vt[0]  = '{H,H,32'h40,32'hDEADBEEF, L,L,32'h0,32'h0,L,         H,L,H,L,32'h0,L,32'h0};
    vt[1]  = '{H,L,32'h40,32'h0,        L,L,32'h0,32'h0,L,         H,L,L,L,32'h0,L,32'h0};
    vt[2]  = '{L,L,32'h0,32'h0,         L,L,32'h0,32'h0,L,         L,L,L,H,32'hDEADBEEF,L,32'h0};
    vt[3]  = '{L,L,32'h0,32'h0,         H,H,32'h10,32'h11112222,L, L,H,H,L,32'h0,L,32'h0};
    vt[4]  = '{H,H,32'h20,32'h33334444, L,L,32'h0,32'h0,L,         H,L,H,L,32'h0,L,32'h0};
    vt[5]  = '{L,L,32'h0,32'h0,         H,L,32'h10,32'h0,L,        L,H,L,L,32'h0,L,32'h0};
    vt[6]  = '{H,L,32'h20,32'h0,        L,L,32'h0,32'h0,L,         H,L,L,L,32'h0,H,32'h11112222};
    vt[7]  = '{L,L,32'h0,32'h0,         L,L,32'h0,32'h0,L,         L,L,L,H,32'h33334444,L,32'h0};
    vt[8]  = '{L,L,32'h0,32'h0,         H,L,32'h40,32'h0,L,        L,H,L,L,32'h0,L,32'h0};
    vt[9]  = '{H,L,32'h10,32'h0,        H,L,32'h20,32'h0,L,        H,L,L,L,32'h0,H,32'hDEADBEEF};
    vt[10] = '{L,L,32'h0,32'h0,         L,L,32'h0,32'h0,L,         L,L,L,H,32'h11112222,L,32'h0};
    for (int i = 0; i < 11; i++) begin
      cpu_req = vt[i].cr; cpu_we = vt[i].cw; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
      dbg_req = vt[i].dr; dbg_we = vt[i].dw; dbg_addr = vt[i].da; dbg_wdata = vt[i].dd;
      dbg_lock = vt[i].dl;
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_gnt", i), {31'b0, cpu_gnt}, {31'b0, vt[i].e_cg});
      chk($sformatf("vec%0d_dbg_gnt", i), {31'b0, dbg_gnt}, {31'b0, vt[i].e_dg});
      chk($sformatf("vec%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vt[i].e_we});
      chk($sformatf("vec%0d_cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, vt[i].e_crv});
      chk($sformatf("vec%0d_dbg_rvalid", i), {31'b0, dbg_rvalid}, {31'b0, vt[i].e_drv});
      if (vt[i].e_crv) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vt[i].e_crd);
      if (vt[i].e_drv) chk($sformatf("vec%0d_dbg_rdata", i), dbg_rdata, vt[i].e_drd);
      next_cyc();
    end
    idle();

    // ---------------- starvation into lock burst ----------------
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 32'h0; dbg_wdata = 32'hA0;
    n = 0;
    @(negedge clk);
    while (!dbg_gnt && n < 20) begin
      chk("starve_cpu_gnt", {31'b0, cpu_gnt}, 1);
      n++;
      next_cyc();
      @(negedge clk);
    end
    chk("starve_denied_cycles", n, MW);
    chk("lock_entry_cpu_gnt", {31'b0, cpu_gnt}, 0);
    chk("lock_entry_mem_we", {31'b0, mem_we}, 1);
    next_cyc();
    for (int k = 1; k < 4; k++) begin
      dbg_addr = 4 * k; dbg_wdata = 32'hA0 + k;
      @(negedge clk);
      chk("lock_dbg_gnt", {31'b0, dbg_gnt}, 1);
      chk("lock_cpu_gnt", {31'b0, cpu_gnt}, 0);
      next_cyc();
    end
    // lock released with a final DBG read: still served as a locked cycle
    dbg_lock = 0; dbg_we = 0; dbg_addr = 32'h0;
    @(negedge clk);
    chk("unlock_dbg_gnt", {31'b0, dbg_gnt}, 1);
    chk("unlock_cpu_gnt", {31'b0, cpu_gnt}, 0);
    next_cyc();
    dbg_req = 0;
    @(negedge clk);
    chk("post_lock_cpu_gnt", {31'b0, cpu_gnt}, 1);
    chk("post_lock_dbg_rvalid", {31'b0, dbg_rvalid}, 1);
    chk("post_lock_dbg_rdata", dbg_rdata, 32'hA0);
    next_cyc();
    for (int k = 0; k < 4; k++) chk($sformatf("burst_mem%0d", k), mem[k], 32'hA0 + k);

    // ---------------- sustained contention: DBG every 9th cycle ----------------
    idle();
    cpu_req = 1; cpu_addr = 32'h40; dbg_req = 1; dbg_addr = 32'h10;
    dg_cnt = 0; cg_cnt = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      chk("period_dbg_gnt", {31'b0, dbg_gnt}, (i % 9 == 8) ? 1 : 0);
      dg_cnt += int'(dbg_gnt); cg_cnt += int'(cpu_gnt);
      next_cyc();
    end
    chk("period_cpu_total", cg_cnt, 24);
    chk("period_dbg_total", dg_cnt, 3);

    // ---------------- reset mid-lock with pending read ----------------
    idle();
    next_cyc();
    dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = 32'h40;
    @(negedge clk);
    chk("rl_dbg_gnt", {31'b0, dbg_gnt}, 1);
    next_cyc();
    cpu_req = 1; dbg_we = 1; dbg_wdata = 32'hBAD0BAD0;
    #1;
    chk("rl_pre_dbg_rvalid", {31'b0, dbg_rvalid}, 1);
    chk("rl_pre_mem_we", {31'b0, mem_we}, 1);
    chk("rl_pre_cpu_gnt", {31'b0, cpu_gnt}, 0);
    rst_n = 0;
    #1;
    chk("rl_dbg_gnt_low", {31'b0, dbg_gnt}, 0);
    chk("rl_cpu_gnt_low", {31'b0, cpu_gnt}, 0);
    chk("rl_mem_we_low", {31'b0, mem_we}, 0);
    chk("rl_rvalids_low", {30'b0, cpu_rvalid, dbg_rvalid}, 0);
    @(posedge clk); #2;
    chk("rl_no_write", mem[16], 32'hDEADBEEF);
    @(negedge clk);
    dbg_we = 0;
    rst_n = 1;
    #1;
    chk("rl_after_cpu_gnt", {31'b0, cpu_gnt}, 1);
    chk("rl_after_dbg_gnt", {31'b0, dbg_gnt}, 0);
    next_cyc();

    // ---------------- randomized traffic vs reference model ----------------
    idle();
    rst_n = 0;
    #3;
    rst_n = 1;
    next_cyc();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    m_locked = 0; m_starve = 0; m_pend_c = 0; m_pend_d = 0; m_rd_c = '0; m_rd_d = '0;
    for (int c = 0; c < 600; c++) begin
      logic e_cg, e_dg, e_we;
      logic [31:0] e_addr, e_wd;
      cpu_req = ($urandom_range(0, 99) < 80);
      cpu_we = $urandom_range(0, 1);
      cpu_addr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      cpu_wdata = $urandom;
      // a pending, un-granted DBG request stays put, like a real requester
      if (!(dbg_req && !dbg_gnt)) begin
        dbg_req = ($urandom_range(0, 99) < 50);
        dbg_we = $urandom_range(0, 1);
        dbg_addr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        dbg_wdata = $urandom;
        dbg_lock = ($urandom_range(0, 99) < 30);
      end else if (m_locked) begin
        dbg_lock = ($urandom_range(0, 99) < 70);
      end
      if (m_locked) e_dg = dbg_req;
      else          e_dg = dbg_req && (!cpu_req || m_starve >= MW);
      e_cg = cpu_req && !m_locked && !e_dg;
      e_we = (e_cg && cpu_we) || (e_dg && dbg_we);
      e_addr = e_dg ? dbg_addr : cpu_addr;
      e_wd = e_dg ? dbg_wdata : cpu_wdata;
      @(negedge clk);
      chk("rnd_cpu_gnt", {31'b0, cpu_gnt}, {31'b0, e_cg});
      chk("rnd_dbg_gnt", {31'b0, dbg_gnt}, {31'b0, e_dg});
      chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, e_we});
      chk("rnd_mem_addr", mem_addr, e_addr);
      if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wd);
      chk("rnd_cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_pend_c});
      chk("rnd_dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, m_pend_d});
      chk("rnd_cpu_rdata", cpu_rdata, m_rd_c);
      chk("rnd_dbg_rdata", dbg_rdata, m_rd_d);
      m_pend_c = e_cg && !cpu_we;
      m_pend_d = e_dg && !dbg_we;
      if (m_pend_c) m_rd_c = ref_mem[cpu_addr[7:2]];
      if (m_pend_d) m_rd_d = ref_mem[dbg_addr[7:2]];
      if (e_we) ref_mem[e_addr[7:2]] = e_wd;
      if (m_locked) begin
        m_starve = 0;
        if (!dbg_req || !dbg_lock) m_locked = 0;
      end else begin
        if (e_dg && dbg_lock) m_locked = 1;
        m_starve = (dbg_req && !e_dg) ? ((m_starve + 1 > MW) ? MW : m_starve + 1) : 0;
      end
      next_cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
